// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-FU skid FIFOs feeding one regfile write port
// via round-robin; WB_ARB_BYPASS_EN adds same-cycle bypass for empty FIFOs.
//
// Ports:
//   clk, rst      clock, async active-high reset
//   fu_i[NFU]     per-FU result payload (pc, id, prd, rdval)
//   fu_i_valid    per-FU result valid (no backpressure to the FU)
//   fu_stall_o    per-FU issue stall, from registered FIFO occupancy
//   wb_o          granted result, zero when idle
//   wb_o_valid    a result is written back this cycle
//   wb_src_o      index of the granted FU, zero when idle
//   overflow_o    sticky: a result was dropped on a full FIFO

package fu_wb_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  id;
    logic [5:0]  prd;
    logic [63:0] rdval;
  } fu_output_t;
endpackage

module fu_wb_arbiter
  import fu_wb_pkg::*;
#(
  parameter int NFU   = 4,
  parameter int DEPTH = 4,
  parameter int SKID  = 2,
  localparam int SW   = (NFU > 1) ? $clog2(NFU) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  fu_output_t       fu_i [NFU],
  input  logic [NFU-1:0]   fu_i_valid,
  output logic [NFU-1:0]   fu_stall_o,
  output fu_output_t       wb_o,
  output logic             wb_o_valid,
  output logic [SW-1:0]    wb_src_o,
  output logic             overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fu_output_t     mem_q [NFU][DEPTH];
  logic [PW-1:0]  wr_q [NFU];
  logic [PW-1:0]  wr_d [NFU];
  logic [PW-1:0]  rd_q [NFU];
  logic [PW-1:0]  rd_d [NFU];
  logic [CW-1:0]  cnt_q [NFU];
  logic [CW-1:0]  cnt_d [NFU];
  logic [SW-1:0]  rr_ptr_q, rr_ptr_d;
  logic           ovf_q, ovf_d;

  logic [NFU-1:0] empty, elig;
  logic [NFU-1:0] pop, push, drop, byp;
  logic           gnt_v;
  logic [SW-1:0]  gnt;

  always_comb begin
    empty = '0;
    elig  = '0;
    for (int i = 0; i < NFU; i++) begin
      empty[i] = (cnt_q[i] == '0);
`ifdef WB_ARB_BYPASS_EN
      elig[i]  = ~empty[i] | (fu_i_valid[i] & ~rst);
`else
      elig[i]  = ~empty[i];
`endif
    end
  end

  // First eligible index at or after rr_ptr, wrapping at NFU.
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NFU; k++) begin
      if (!gnt_v && elig[(int'(rr_ptr_q) + k) % NFU]) begin
        gnt_v = 1'b1;
        gnt   = SW'((int'(rr_ptr_q) + k) % NFU);
      end
    end
  end

  always_comb begin
    wb_o       = '0;
    wb_o_valid = gnt_v;
    wb_src_o   = gnt;
    pop        = '0;
    byp        = '0;
    if (gnt_v) begin
`ifdef WB_ARB_BYPASS_EN
      if (empty[gnt]) begin
        byp[gnt] = 1'b1;
        wb_o     = fu_i[gnt];
      end else begin
        pop[gnt] = 1'b1;
        wb_o     = mem_q[gnt][rd_q[gnt]];
      end
`else
      pop[gnt] = 1'b1;
      wb_o     = mem_q[gnt][rd_q[gnt]];
`endif
    end
  end

  // A full FIFO still accepts when it is popped the same cycle.
  always_comb begin
    push       = '0;
    drop       = '0;
    fu_stall_o = '0;
    for (int i = 0; i < NFU; i++) begin
      push[i] = fu_i_valid[i] & ~byp[i] &
                ((cnt_q[i] != CW'(DEPTH)) | pop[i]);
      drop[i] = fu_i_valid[i] & ~byp[i] &
                (cnt_q[i] == CW'(DEPTH)) & ~pop[i];
      wr_d[i]  = wr_q[i] + PW'(push[i]);
      rd_d[i]  = rd_q[i] + PW'(pop[i]);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      fu_stall_o[i] = ~rst &
                      ((DEPTH - int'(cnt_q[i])) <= SKID);
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_v) begin
      rr_ptr_d = (gnt == SW'(NFU - 1)) ? '0 : gnt + 1'b1;
    end
    ovf_d = ovf_q | (|drop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NFU; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      rr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NFU; i++) begin
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NFU; i++) begin
      if (push[i]) mem_q[i][wr_q[i]] <= fu_i[i];
    end
  end

  assign overflow_o = ovf_q;

endmodule
